// File: rtl/data_sram_bridge.sv
// MEM-stage data-SRAM to request/handshake bus bridge. It stalls the pipeline while an access
// is in flight, returns extended load data, and cancels or drains the access on a flush.
`timescale 1ns/1ps
module data_sram_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [3:0]        data_sram_wen,
  input  logic [DATA_W-1:0] data_sram_wdata,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [2:0]        memR,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_result,
  output logic              out_valid
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [2:0]        memr_q, memr_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] load_q, load_d;

  logic              access;
  logic              is_store;
  logic [1:0]        req_size;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] ext_data;

  assign is_store = (data_sram_wen != 4'b0000);
  assign access   = in_valid & (is_store | (memR != 3'b000));

  // A store takes priority over any load type presented alongside it.
  always_comb begin
    req_size = 2'd2;
    if (is_store) begin
      case (data_sram_wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'd0;
        4'b0011, 4'b0110, 4'b1100:          req_size = 2'd1;
        default:                            req_size = 2'd2;
      endcase
    end else begin
      case (memR)
        3'd1, 3'd2: req_size = 2'd0;
        3'd3, 3'd4: req_size = 2'd1;
        default:    req_size = 2'd2;
      endcase
    end
  end

  always_comb begin
    rd_byte  = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = bus_rdata[{addr_q[1], 4'b0000} +: 16];
    ext_data = bus_rdata;
    case (memr_q)
      3'd1:    ext_data = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      3'd2:    ext_data = {{(DATA_W-8){1'b0}}, rd_byte};
      3'd3:    ext_data = {{(DATA_W-16){rd_half[15]}}, rd_half};
      3'd4:    ext_data = {{(DATA_W-16){1'b0}}, rd_half};
      default: ext_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    memr_d  = memr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    load_d  = load_q;
    case (state_q)
      StIdle: begin
        if (access && !flush) begin
          addr_d  = data_sram_addr;
          wdata_d = data_sram_wdata;
          wstrb_d = data_sram_wen;
          memr_d  = is_store ? 3'd0 : memR;
          wr_d    = is_store;
          size_d  = req_size;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus_addr_ok) begin
          if (flush) begin
            // Accepted request must complete on the bus; data is thrown away.
            state_d = bus_data_ok ? StIdle : StDrain;
          end else if (bus_data_ok) begin
            if (!wr_q) load_d = ext_data;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (bus_data_ok) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            if (!wr_q) load_d = ext_data;
            state_d = StDone;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDone:  state_d = StIdle;
      StDrain: if (bus_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      memr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      memr_q  <= memr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    bus_req     = (state_q == StReq);
    bus_wr      = bus_req & wr_q;
    bus_size    = bus_req ? size_q : 2'd0;
    bus_wstrb   = bus_req ? wstrb_q : 4'd0;
    bus_addr    = bus_req ? addr_q : '0;
    bus_wdata   = bus_req ? wdata_q : '0;
    load_result = load_q;
    out_valid   = (state_q == StDone) & ~flush;
    // Reset gating keeps the pipeline free while resetn is held low.
    if (!resetn)                 mem_stall = 1'b0;
    else if (state_q == StDrain) mem_stall = 1'b1;
    else if (flush)              mem_stall = 1'b0;
    else                         mem_stall = access & (state_q != StDone);
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: transaction-level scoreboard plus directed scenarios.
`timescale 1ns/1ps
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_addr;
  logic [2:0]  memR;
  logic        flush;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] load_result;
  logic        out_valid;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .data_sram_wen(data_sram_wen),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr(data_sram_addr), .memR(memR),
    .flush(flush), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .load_result(load_result), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_load;
    logic [31:0] res;
  } cpl_t;

  req_t        req_q[$];
  cpl_t        cpl_q[$];
  logic [31:0] model_res = 32'h0;
  int          checks = 0;
  int          failures = 0;
  logic        seen_wr;
  logic [1:0]  seen_size;
  logic [3:0]  seen_wstrb;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic req_t exp_req(input logic [3:0] wen, input logic [31:0] wd,
                                   input logic [31:0] addr, input logic [2:0] mr);
    req_t r;
    r.wr    = (wen != 4'd0);
    r.wstrb = wen;
    r.addr  = addr;
    r.wdata = wd;
    if (r.wr) r.size = ($countones(wen) == 1) ? 2'd0 : ($countones(wen) == 2) ? 2'd1 : 2'd2;
    else      r.size = (mr <= 3'd2) ? 2'd0 : (mr <= 3'd4) ? 2'd1 : 2'd2;
    return r;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [2:0] mr, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    case (mr)
      3'd1:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return h;
      default: return rdata;
    endcase
  endfunction

  // Scoreboard: requests checked at acceptance, completions at out_valid, load_result always.
  always @(negedge clk) begin
    if (!resetn) begin
      model_res = 32'h0;
      req_q.delete();
      cpl_q.delete();
      chk("reset_outputs", {29'd0, bus_req, out_valid, mem_stall}, 32'd0);
    end else begin
      if (bus_req && bus_addr_ok) begin
        if (req_q.size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_wr", {31'd0, bus_wr}, {31'd0, r.wr});
          chk("req_size", {30'd0, bus_size}, {30'd0, r.size});
          chk("req_wstrb", {28'd0, bus_wstrb}, {28'd0, r.wr ? r.wstrb : 4'd0});
          chk("req_addr", bus_addr, r.addr);
          if (r.wr) chk("req_wdata", bus_wdata, r.wdata);
        end
      end
      if (out_valid) begin
        if (cpl_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          cpl_t c;
          c = cpl_q.pop_front();
          if (c.is_load) model_res = c.res;
        end
      end
    end
    chk("load_result", load_result, model_res);
  end

  task automatic idle_inputs();
    in_valid = 0; data_sram_wen = 0; data_sram_wdata = 0; data_sram_addr = 0; memR = 0;
    flush = 0; bus_addr_ok = 0; bus_data_ok = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full access with a responder that grants after ao stall cycles and returns data dd
  // cycles after acceptance. Called and returns at posedge+1.
  task automatic run_access(input string nm, input logic [3:0] wen, input logic [31:0] wd,
                            input logic [31:0] addr, input logic [2:0] mr, input int ao,
                            input int dd, input logic [31:0] rd, input int exp_cyc);
    cpl_t c;
    int   cyc, stalls, wa, dw;
    bit   acc, dn, fin;
    req_q.push_back(exp_req(wen, wd, addr, mr));
    c.is_load = (wen == 4'd0);
    c.res     = exp_ext(mr, addr, rd);
    cpl_q.push_back(c);
    in_valid = 1; data_sram_wen = wen; data_sram_wdata = wd; data_sram_addr = addr; memR = mr;
    cyc = 0; stalls = 0; wa = 0; dw = 0; acc = 0; dn = 0; fin = 0;
    while (!fin && cyc < 40) begin
      bus_addr_ok = 0;
      bus_data_ok = 0;
      if (bus_req && !acc) begin
        if (wa >= ao) begin
          bus_addr_ok = 1; acc = 1;
          if (dd == 0) begin bus_data_ok = 1; bus_rdata = rd; dn = 1; end
        end else begin
          wa++;
        end
      end else if (acc && !dn) begin
        dw++;
        if (dw >= dd) begin bus_data_ok = 1; bus_rdata = rd; dn = 1; end
      end
      #1;
      if (bus_addr_ok) begin seen_wr = bus_wr; seen_size = bus_size; seen_wstrb = bus_wstrb; end
      if (mem_stall) stalls++;
      else begin
        fin = 1;
        chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      end
      cyc++;
      step();
    end
    idle_inputs();
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_stall_cycles"}, stalls, exp_cyc - 1);
  endtask

  initial begin
    resetn = 0;
    bus_rdata = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_result", load_result, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    resetn = 1;
    step();

    run_access("sw", 4'b1111, 32'hDEADBEEF, 32'h0000_1004, 3'd0, 1, 2, 32'h0, 6);
    chk("sw_lit_wr", {31'd0, seen_wr}, 32'd1);
    chk("sw_lit_size", {30'd0, seen_size}, 32'd2);
    chk("sw_lit_wstrb", {28'd0, seen_wstrb}, 32'hF);
    run_access("lb", 4'd0, 32'h0, 32'h0000_0103, 3'd1, 0, 0, 32'h80FF_1234, 3);
    chk("lb_lit", load_result, 32'hFFFF_FF80);
    run_access("lbu", 4'd0, 32'h0, 32'h0000_0103, 3'd2, 0, 0, 32'h80FF_1234, 3);
    chk("lbu_lit", load_result, 32'h0000_0080);
    run_access("lh", 4'd0, 32'h0, 32'h0000_0102, 3'd3, 0, 1, 32'h8001_7FFF, 4);
    chk("lh_lit", load_result, 32'hFFFF_8001);
    chk("lh_lit_size", {30'd0, seen_size}, 32'd1);
    run_access("lhu", 4'd0, 32'h0, 32'h0000_0100, 3'd4, 1, 0, 32'h8001_7FFF, 4);
    chk("lhu_lit", load_result, 32'h0000_7FFF);
    run_access("lw", 4'd0, 32'h0, 32'h0000_0200, 3'd5, 2, 1, 32'hCAFE_F00D, 6);
    chk("lw_lit", load_result, 32'hCAFE_F00D);
    run_access("sb", 4'b0010, 32'h0000_AB00, 32'h0000_0301, 3'd0, 0, 3, 32'h1111_1111, 6);
    chk("sb_keeps_result", load_result, 32'hCAFE_F00D);
    run_access("st_wins", 4'b1100, 32'h5A5A_0000, 32'h0000_0302, 3'd5, 0, 0, 32'h2222_2222, 3);
    chk("st_wins_wr", {31'd0, seen_wr}, 32'd1);
    chk("st_wins_result", load_result, 32'hCAFE_F00D);

    // Flush in IDLE: no request issued.
    in_valid = 1; memR = 3'd5; data_sram_addr = 32'h0000_0380; flush = 1;
    #1 chk("flush_idle_stall", {31'd0, mem_stall}, 32'd0);
    step();
    idle_inputs();
    #1 chk("flush_idle_no_req", {31'd0, bus_req}, 32'd0);
    step();

    // Flush in REQ before addr_ok: request withdrawn.
    in_valid = 1; data_sram_wen = 4'b0001; data_sram_addr = 32'h0000_0390;
    step();
    flush = 1;
    #1 chk("flush_req_stall", {31'd0, mem_stall}, 32'd0);
    step();
    idle_inputs();
    #1 chk("flush_req_dropped", {31'd0, bus_req}, 32'd0);
    step();

    // Flush in WAIT: drain, discard data.
    req_q.push_back(exp_req(4'd0, 32'h0, 32'h0000_0400, 3'd5));
    in_valid = 1; memR = 3'd5; data_sram_addr = 32'h0000_0400;
    #1 chk("drain_idle_stall", {31'd0, mem_stall}, 32'd1);
    step();
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0; flush = 1;
    #1 chk("drain_flush_stall", {31'd0, mem_stall}, 32'd0);
    step();
    idle_inputs();
    #1 chk("drain_stall_a", {31'd0, mem_stall}, 32'd1);
    step();
    #1 chk("drain_stall_b", {31'd0, mem_stall}, 32'd1);
    step();
    bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    step();
    bus_data_ok = 0;
    #1 chk("drain_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("drain_no_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_keeps_result", load_result, 32'hCAFE_F00D);
    step();

    // Flush in DONE: out_valid suppressed.
    req_q.push_back(exp_req(4'b1111, 32'h0BAD_F00D, 32'h0000_0500, 3'd0));
    in_valid = 1; data_sram_wen = 4'b1111; data_sram_wdata = 32'h0BAD_F00D;
    data_sram_addr = 32'h0000_0500;
    step();
    bus_addr_ok = 1; bus_data_ok = 1;
    step();
    bus_addr_ok = 0; bus_data_ok = 0; flush = 1;
    #1 chk("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done_stall", {31'd0, mem_stall}, 32'd0);
    step();
    idle_inputs();
    #1 chk("flush_done_idle", {31'd0, bus_req}, 32'd0);
    step();

    // Reset while in REQ, then a stray data_ok, then a byte store.
    in_valid = 1; memR = 3'd5; data_sram_addr = 32'h0000_0600;
    step();
    chk("rst_req_pre", {31'd0, bus_req}, 32'd1);
    resetn = 0;
    #1 chk("rst_req_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_req_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_req_result", load_result, 32'h0);
    idle_inputs();
    step();
    resetn = 1;
    step();
    bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
    #1 chk("stray_no_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    bus_data_ok = 0;
    #1 chk("stray_no_req", {31'd0, bus_req}, 32'd0);
    chk("stray_no_stall", {31'd0, mem_stall}, 32'd0);
    step();
    run_access("sb_after_rst", 4'b0100, 32'h00AB_0000, 32'h0000_0702, 3'd0, 0, 1, 32'h0, 4);
    chk("sb_rst_lit_size", {30'd0, seen_size}, 32'd0);
    chk("sb_rst_lit_wstrb", {28'd0, seen_wstrb}, 32'h4);

    step();
    chk("req_queue_empty", req_q.size(), 32'd0);
    chk("cpl_queue_empty", cpl_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
Sits directly downstream of the store-formatting stage in the MEM stage. It turns the per-instruction data-SRAM request (byte enables, shifted write data, masked address, load type) into a request/handshake bus transaction. It stalls the pipeline until the transaction completes, then returns sign- or zero-extended, byte-aligned load data to write-back. It also supports a pipeline flush that cancels or drains an in-flight access.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (fixed 32; byte lanes = 4)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  MEM-stage instruction valid
data_sram_wen  in  4  store byte enables from store formatter; 0 = not a store
data_sram_wdata  in  32  lane-shifted store data
data_sram_addr  in  32  physical address (already masked)
memR  in  3  load type: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw
flush  in  1  cancel current MEM access (exception/redirect)
bus_req  out  1  request valid
bus_wr  out  1  1 = write, 0 = read
bus_size  out  2  0 byte, 1 half, 2 word
bus_wstrb  out  4  write strobes
bus_addr  out  32  request address
bus_wdata  out  32  write data
bus_addr_ok  in  1  request accepted this cycle
bus_data_ok  in  1  write done / read data valid this cycle
bus_rdata  in  32  read data
mem_stall  out  1  hold pipeline
load_result  out  32  extended load data
out_valid  out  1  access completed (one-cycle pulse)

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset → IDLE. All outputs 0 during reset. load_result and the latched request registers also reset to 0.
- Access = in_valid & (data_sram_wen != 0 | memR != 0). If both a store and a load are indicated, the store wins and memR is ignored.
- IDLE: on access with !flush, latch addr, wdata, wstrb, memR, wr and size, then go to REQ next edge.
- size is decoded from wen: 0001/0010/0100/1000 → 0; 0011/0110/1100 → 1; 1111 → 2.
- Load size: lb/lbu → 0, lh/lhu → 1, lw → 2. For a read, bus_wstrb = 0.
- REQ: bus_req = 1 with the latched fields, held stable until addr_ok.
  - addr_ok & !data_ok → WAIT.
  - addr_ok & data_ok in the same cycle → DONE, capturing rdata.
- WAIT: bus_req = 0. data_ok → DONE, capturing rdata.
- DONE: exactly one cycle with out_valid = 1 and mem_stall = 0, then → IDLE.
  - load_result holds until the next DONE.
  - For stores, load_result is unchanged.
- mem_stall = access & (state != DONE), with these exceptions:
  - Forced 0 when flush is high.
  - Forced 1 in DRAIN.
  - The first access cycle (IDLE) stalls combinationally, giving a minimum 3-cycle access: IDLE→REQ→DONE when addr_ok and data_ok coincide.
- Load extend, using byte = rdata[8*addr[1:0] +: 8] and half = rdata[16*addr[1] +: 16]:
  - lb: sign-extend byte; lbu: zero-extend byte.
  - lh: sign-extend half; lhu: zero-extend half.
  - lw: rdata unchanged.
- Flush:
  - In IDLE: no request is issued.
  - In REQ before addr_ok: drop bus_req and go to IDLE.
  - In REQ with addr_ok the same cycle, or in WAIT: go to DRAIN, wait for data_ok, discard the data (no out_valid, load_result unchanged), then go to IDLE.
  - In DONE: out_valid is suppressed.
- In IDLE, a stray data_ok (e.g. after reset mid-transaction) is ignored.
- An asynchronous reset mid-operation returns the block to IDLE immediately and drops bus_req.
- No address-alignment checking; misaligned wstrb patterns are passed through unchanged.

Test Plan:
- sw 0xDEADBEEF @0x00001004, wen 1111; addr_ok at cycle 2, data_ok at cycle 4 → bus_wr=1, size=2, wstrb=1111; mem_stall high until DONE; out_valid pulses once.
- lb @0x...03 with rdata 0x80FF_1234 → load_result 0xFFFFFF80. Same access as lbu → 0x00000080.
- lh @0x...02 with rdata 0x8001_7FFF → load_result 0xFFFF8001. lhu @0x...00 on the same data → 0x00007FFF.
- addr_ok and data_ok in the same cycle as REQ → DONE on the next edge; total 3 cycles from access start to pipeline advance.
- flush asserted in WAIT; data_ok 3 cycles later with rdata 0x12345678 → no out_valid; load_result keeps its prior value; back in IDLE after data_ok.
- resetn pulled low while in REQ → bus_req=0 and mem_stall=0 immediately; a later stray data_ok is ignored; the next sb (wen 0100) issues size=0, wstrb=0100.
